// File: rtl/wt_cache_pkg.sv
// Shared types and defaults for the write-through cache memory path.
package wt_cache_pkg;

    // Owner of a memory transaction, as carried on mem_src_o / rtrn_src_i.
    typedef enum logic {
        MEM_SRC_ICACHE = 1'b0,
        MEM_SRC_DCACHE = 1'b1
    } mem_src_e;

    // Default per-source in-flight transaction limit.
    localparam int unsigned MEM_MAX_OUTSTANDING = 4;

    // Default width of the opaque request payload.
    localparam int unsigned MEM_REQ_WIDTH = 128;

endpackage

// File: rtl/wt_mem_src_cnt.sv
// Saturating up/down outstanding-transaction counter for one request source.
// A decrement at zero leaves the count alone and raises underflow_o for that
// cycle so the parent can latch a protocol error.
module wt_mem_src_cnt #(
    parameter  int unsigned MaxOutstanding = 4,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                full_o,
    output logic                underflow_o
);

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;
    logic                empty;

    assign empty       = (cnt_q == '0);
    assign full_o      = (cnt_q == CntWidth'(MaxOutstanding));
    assign underflow_o = dec_i & empty;
    assign cnt_o       = cnt_q;

    // Next count: +1 on capture, -1 on return, unchanged when both happen.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            if (!full_o) cnt_d = cnt_q + CntWidth'(1);
        end else if (!inc_i && dec_i) begin
            if (!empty) cnt_d = cnt_q - CntWidth'(1);
        end else if (inc_i && dec_i && empty) begin
            // The return is bogus (flagged as underflow) but the capture is real.
            cnt_d = CntWidth'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter putting I$ and D$ requests onto the single memory
// request channel, with per-source outstanding tracking, return routing,
// a drain handshake and a sticky protocol-error flag.
//
// Handshakes: a cache raises *_req_i with stable *_data_i and holds both until
// *_ack_o pulses (capture happens that cycle). Toward the adapter mem_req_o is
// a valid that, once high, keeps mem_data_o/mem_src_o stable until a cycle
// with mem_gnt_i=1 (the ready); that same cycle the slot may be refilled.
module wt_mem_arbiter
    import wt_cache_pkg::*;
#(
    parameter  int unsigned ReqWidth       = MEM_REQ_WIDTH,
    parameter  int unsigned MaxOutstanding = MEM_MAX_OUTSTANDING,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                icache_req_i,
    input  logic [ReqWidth-1:0] icache_data_i,
    output logic                icache_ack_o,
    input  logic                dcache_req_i,
    input  logic [ReqWidth-1:0] dcache_data_i,
    output logic                dcache_ack_o,
    output logic                mem_req_o,
    output logic [ReqWidth-1:0] mem_data_o,
    output logic                mem_src_o,
    input  logic                mem_gnt_i,
    input  logic                rtrn_vld_i,
    input  logic                rtrn_src_i,
    output logic                icache_rtrn_vld_o,
    output logic                dcache_rtrn_vld_o,
    input  logic                drain_i,
    output logic                drain_done_o,
    output logic                err_o
);

    logic                mem_req_q;
    logic [ReqWidth-1:0] mem_data_q;
    mem_src_e            mem_src_q;
    logic                rr_dcache_q;   // 1: D$ wins a tie next time
    logic                err_q;

    logic                slot_free;
    logic                icache_elig, dcache_elig;
    logic                icache_win, dcache_win;
    logic                icache_full, dcache_full;
    logic                icache_unf, dcache_unf;
    logic [CntWidth-1:0] icache_cnt, dcache_cnt;

    // The slot can take a new request when empty or when the held one leaves now.
    assign slot_free   = ~mem_req_q | mem_gnt_i;
    assign icache_elig = icache_req_i & ~icache_full & ~drain_i & slot_free;
    assign dcache_elig = dcache_req_i & ~dcache_full & ~drain_i & slot_free;
    assign icache_win  = icache_elig & (~dcache_elig | ~rr_dcache_q);
    assign dcache_win  = dcache_elig & (~icache_elig |  rr_dcache_q);

    assign icache_ack_o      = icache_win;
    assign dcache_ack_o      = dcache_win;
    assign icache_rtrn_vld_o = rtrn_vld_i & ~rtrn_src_i;
    assign dcache_rtrn_vld_o = rtrn_vld_i &  rtrn_src_i;

    assign mem_req_o    = mem_req_q;
    assign mem_data_o   = mem_data_q;
    assign mem_src_o    = mem_src_q;
    assign err_o        = err_q;
    assign drain_done_o = drain_i & ~mem_req_q & (icache_cnt == '0) & (dcache_cnt == '0);

    wt_mem_src_cnt #(.MaxOutstanding(MaxOutstanding)) u_icache_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (icache_win),
        .dec_i       (icache_rtrn_vld_o),
        .cnt_o       (icache_cnt),
        .full_o      (icache_full),
        .underflow_o (icache_unf)
    );

    wt_mem_src_cnt #(.MaxOutstanding(MaxOutstanding)) u_dcache_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (dcache_win),
        .dec_i       (dcache_rtrn_vld_o),
        .cnt_o       (dcache_cnt),
        .full_o      (dcache_full),
        .underflow_o (dcache_unf)
    );

    // Round-robin pointer: after any win, favour the other source.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         rr_dcache_q <= 1'b0;
        else if (icache_win) rr_dcache_q <= 1'b1;
        else if (dcache_win) rr_dcache_q <= 1'b0;
    end

    // Output register: load the winner, drop valid on grant, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_req_q  <= 1'b0;
            mem_data_q <= '0;
            mem_src_q  <= MEM_SRC_ICACHE;
        end else if (icache_win || dcache_win) begin
            mem_req_q  <= 1'b1;
            mem_data_q <= dcache_win ? dcache_data_i : icache_data_i;
            mem_src_q  <= dcache_win ? MEM_SRC_DCACHE : MEM_SRC_ICACHE;
        end else if (mem_gnt_i) begin
            mem_req_q  <= 1'b0;
        end
    end

    // Sticky error on any return that has no matching outstanding transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_q | icache_unf | dcache_unf;
    end

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed bench for wt_mem_arbiter: a vector table for single-cycle behaviour
// plus hand-written multi-cycle sequences for limits, drain, errors and reset.
module tb_wt_mem_arbiter;

    localparam int W = 128;

    // clock / reset
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic         icache_req, dcache_req, icache_ack, dcache_ack;
    logic [W-1:0] icache_data, dcache_data, mem_data;
    logic         mem_req, mem_src, mem_gnt, rtrn_vld, rtrn_src;
    logic         icache_rtrn_vld, dcache_rtrn_vld, drain, drain_done, err;

    wt_mem_arbiter dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .icache_req_i      (icache_req),
        .icache_data_i     (icache_data),
        .icache_ack_o      (icache_ack),
        .dcache_req_i      (dcache_req),
        .dcache_data_i     (dcache_data),
        .dcache_ack_o      (dcache_ack),
        .mem_req_o         (mem_req),
        .mem_data_o        (mem_data),
        .mem_src_o         (mem_src),
        .mem_gnt_i         (mem_gnt),
        .rtrn_vld_i        (rtrn_vld),
        .rtrn_src_i        (rtrn_src),
        .icache_rtrn_vld_o (icache_rtrn_vld),
        .dcache_rtrn_vld_o (dcache_rtrn_vld),
        .drain_i           (drain),
        .drain_done_o      (drain_done),
        .err_o             (err)
    );

    // scoreboard counters
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: apply inputs at the falling edge, then wait to the sample point
    task automatic drive(input logic ir, input logic [W-1:0] id, input logic dr,
                         input logic [W-1:0] dd, input logic g, input logic rv,
                         input logic rs, input logic dn);
        @(negedge clk);
        icache_req = ir; icache_data = id; dcache_req = dr; dcache_data = dd;
        mem_gnt = g; rtrn_vld = rv; rtrn_src = rs; drain = dn;
        #3;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        icache_req = 0; icache_data = '0; dcache_req = 0; dcache_data = '0;
        mem_gnt = 0; rtrn_vld = 0; rtrn_src = 0; drain = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    typedef struct {
        logic ir; logic [15:0] id; logic dr; logic [15:0] dd;
        logic g; logic rv; logic rs; logic dn;
        logic e_iack; logic e_dack; logic e_mreq; logic e_msrc; logic [15:0] e_mdata;
        logic [2:0] e_icnt; logic [2:0] e_dcnt; logic e_irtrn; logic e_drtrn;
    } vec_t;

    vec_t vt[13];
    int   acks;
    logic [W-1:0] pay;

    initial begin
        // ir id      dr dd      g  rv rs dn  iack dack mreq msrc mdata   icnt dcnt irt drt
        vt[0]  = '{1'b0, 16'h00, 1'b1, 16'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00, 3'd0, 3'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5, 3'd0, 3'd1, 1'b0, 1'b0};
        vt[2]  = vt[1];
        vt[3]  = vt[1];
        vt[4]  = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5, 3'd0, 3'd1, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00, 3'd0, 3'd1, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 16'h11, 1'b1, 16'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00, 3'd0, 3'd0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 16'h13, 1'b1, 16'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h11, 3'd1, 3'd0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 16'h13, 1'b1, 16'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h22, 3'd1, 3'd1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 16'h15, 1'b1, 16'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h13, 3'd2, 3'd1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h24, 3'd2, 3'd2, 1'b0, 1'b0};
        vt[11] = '{1'b1, 16'h31, 1'b0, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00, 3'd2, 3'd2, 1'b1, 1'b0};
        vt[12] = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h31, 3'd2, 3'd2, 1'b0, 1'b0};

        // reset state
        apply_reset();
        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_mem_src", mem_src, 0);
        check("rst_err", err, 0);
        check("rst_acks", {icache_ack, dcache_ack}, 0);

        // table: D$ alone with gnt stall, alternation, same-cycle capture/return
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].ir, W'(vt[i].id), vt[i].dr, W'(vt[i].dd), vt[i].g, vt[i].rv, vt[i].rs, vt[i].dn);
            check($sformatf("v%0d_iack", i), icache_ack, vt[i].e_iack);
            check($sformatf("v%0d_dack", i), dcache_ack, vt[i].e_dack);
            check($sformatf("v%0d_mreq", i), mem_req, vt[i].e_mreq);
            if (vt[i].e_mreq) begin
                check($sformatf("v%0d_msrc", i), mem_src, vt[i].e_msrc);
                check($sformatf("v%0d_mdata", i), mem_data, W'(vt[i].e_mdata));
            end
            check($sformatf("v%0d_icnt", i), dut.icache_cnt, vt[i].e_icnt);
            check($sformatf("v%0d_dcnt", i), dut.dcache_cnt, vt[i].e_dcnt);
            check($sformatf("v%0d_irtrn", i), icache_rtrn_vld, vt[i].e_irtrn);
            check($sformatf("v%0d_drtrn", i), dcache_rtrn_vld, vt[i].e_drtrn);
            check($sformatf("v%0d_err", i), err, 0);
        end

        // I$ outstanding limit: exactly 4 captures, then one return frees a slot
        apply_reset();
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1, W'($urandom_range(255)), 0, '0, 1, 0, 0, 0);
            if (icache_ack && dcache_ack) check("max_double_ack", 1, 0);
            if (icache_ack) acks++;
            if (c >= 4) check($sformatf("max_no_ack_c%0d", c), icache_ack, 0);
        end
        check("max_ack_count", acks, 4);
        check("max_icnt", dut.icache_cnt, 4);
        drive(1, W'(16'h55), 0, '0, 1, 1, 0, 0);
        check("max_rtrn_cycle_ack", icache_ack, 0);
        check("max_rtrn_irtrn", icache_rtrn_vld, 1);
        drive(1, W'(16'h55), 0, '0, 1, 0, 0, 0);
        check("max_after_rtrn_ack", icache_ack, 1);

        // drain with one held D$ request
        apply_reset();
        pay = W'($urandom_range(16'hFFFF));
        drive(0, '0, 1, pay, 0, 0, 0, 0);
        check("drn_dack", dcache_ack, 1);
        drive(1, W'(16'h99), 0, '0, 0, 0, 0, 1);
        check("drn_c1_iack", icache_ack, 0);
        check("drn_c1_done", drain_done, 0);
        check("drn_c1_mdata", mem_data, pay);
        drive(1, W'(16'h99), 0, '0, 1, 0, 0, 1);
        check("drn_c2_iack", icache_ack, 0);
        check("drn_c2_mreq", mem_req, 1);
        check("drn_c2_msrc", mem_src, 1);
        drive(1, W'(16'h99), 0, '0, 0, 0, 0, 1);
        check("drn_c3_iack", icache_ack, 0);
        check("drn_c3_mreq", mem_req, 0);
        check("drn_c3_done", drain_done, 0);
        drive(1, W'(16'h99), 0, '0, 0, 1, 1, 1);
        check("drn_c4_drtrn", dcache_rtrn_vld, 1);
        check("drn_c4_done", drain_done, 0);
        drive(1, W'(16'h99), 0, '0, 0, 0, 0, 1);
        check("drn_c5_done", drain_done, 1);
        check("drn_c5_iack", icache_ack, 0);
        drive(1, W'(16'h99), 0, '0, 0, 0, 0, 0);
        check("drn_resume_iack", icache_ack, 1);
        check("drn_resume_done", drain_done, 0);

        // underflow error is sticky; async reset mid-transfer clears everything
        apply_reset();
        drive(0, '0, 0, '0, 0, 1, 1, 0);
        check("err_c0_err", err, 0);
        check("err_c0_drtrn", dcache_rtrn_vld, 1);
        drive(0, '0, 0, '0, 0, 0, 0, 0);
        check("err_set", err, 1);
        check("err_dcnt", dut.dcache_cnt, 0);
        drive(0, '0, 0, '0, 0, 0, 0, 0);
        drive(0, '0, 0, '0, 0, 0, 0, 0);
        check("err_sticky", err, 1);
        drive(0, '0, 1, W'(16'h77), 0, 0, 0, 0);
        check("ar_dack", dcache_ack, 1);
        drive(0, '0, 0, '0, 0, 0, 0, 0);
        check("ar_mreq_before", mem_req, 1);
        rst_ni = 1'b0;
        #1;
        check("ar_mreq", mem_req, 0);
        check("ar_mdata", mem_data, 0);
        check("ar_msrc", mem_src, 0);
        check("ar_err", err, 0);
        check("ar_dcnt", dut.dcache_cnt, 0);
        check("ar_acks", {icache_ack, dcache_ack}, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        drive(0, '0, 0, '0, 0, 0, 0, 0);
        check("ar_err_after", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
